uart_tx_periph: RTL and testbench
=================================

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 Parameter BASE_ADDR, default 8'hE0, meaning: base of the 3-register window (BASE+0 TX_DATA, BASE+1 STATUS, BASE+2 CTRL).
REQ-002 Parameter BAUD_DIV, default 868, meaning: clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 BUS_ADDR  input  8  shared CPU bus address.
REQ-006 BUS_DATA  inout  8  shared CPU bus data; driven only during a read response, high-Z otherwise.
REQ-007 BUS_WE  input  1  bus write strobe; a write occurs when high with an address in the window.
REQ-008 BUS_INTERRUPT_RAISE  output  1  transmit-complete interrupt request to the CPU.
REQ-009 BUS_INTERRUPT_ACK  input  1  CPU acknowledge for BUS_INTERRUPT_RAISE.
REQ-010 TX  output  1  serial line out, idle high.

Function
REQ-011 Write to BASE+0 SHALL push BUS_DATA into a 4-entry FIFO.
- FIFO full: byte dropped, sticky OVERRUN set.
REQ-012 Write to BASE+2 SHALL load CTRL[0] = IRQ_EN; other bits ignored.
- Writes to other addresses: no effect.
REQ-013 Read (BUS_WE low, BUS_ADDR in window) at cycle N SHALL drive BUS_DATA during cycle N+1 only, from a registered value.
- BASE+0 returns 8'h00.
- BASE+1 returns {4'b0, OVERRUN, IRQ_EN, FULL, BUSY}.
- BASE+2 returns {7'b0, IRQ_EN}.
REQ-014 Reading STATUS SHALL clear OVERRUN on the cycle after the read; an overrun in that same cycle keeps OVERRUN set.
REQ-015 BUSY SHALL be 1 when the FIFO is non-empty or the shifter is not IDLE.
REQ-016 FULL SHALL be 1 when the FIFO holds 4 bytes.
REQ-017 The FIFO SHALL use 2-bit wrapping read/write pointers plus a 3-bit count.
- Simultaneous push and pop on a full FIFO is legal: count stays at 4, byte accepted.
REQ-018 Shifter FSM states: IDLE, START, DATA, STOP.
- IDLE->START when the FIFO is non-empty: pop the byte, load the shift register, clear the baud counter.
- START: TX=0 for BAUD_DIV cycles.
- DATA: 8 bits, LSB first, BAUD_DIV cycles each.
- STOP: TX=1 for BAUD_DIV cycles; then START if the FIFO is non-empty (back-to-back, no idle gap), else IDLE.
REQ-019 Latency: write at cycle N to an empty FIFO with the FSM in IDLE SHALL make TX fall at cycle N+2. A frame is exactly 10*BAUD_DIV cycles.
REQ-020 The baud counter SHALL be 16 bits, count 0..BAUD_DIV-1, and wrap to 0 on each bit boundary.
REQ-021 On the STOP->IDLE transition with IRQ_EN=1, BUS_INTERRUPT_RAISE SHALL be set the next cycle.
- Held until BUS_INTERRUPT_ACK is sampled high, then cleared the next cycle.
- A new completion event in the same cycle as ACK leaves RAISE at 1.
REQ-022 Clearing IRQ_EN SHALL NOT clear a pending RAISE; only ACK or RESET clears it.
REQ-023 Writes during an active frame SHALL NOT disturb the frame in progress.

Reset
REQ-024 With RESET high at a clock edge, the following SHALL hold at the next cycle:
- TX=1
- BUS_INTERRUPT_RAISE=0
- BUS_DATA high-Z
- FSM=IDLE, FIFO empty, pointers and count 0
- IRQ_EN=0, OVERRUN=0, baud counter 0
REQ-025 RESET mid-frame SHALL abort the frame: TX returns to 1 the cycle after RESET is sampled, and queued bytes are discarded.
REQ-026 While RESET is high, bus writes SHALL be ignored and no read response is driven.

Verification (BAUD_DIV=4, BASE_ADDR=8'hE0)
REQ-027 Single byte: write 8'hA5 to E0 at cycle 0 -> TX reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting at cycle 2; BUSY=0 after cycle 42.
REQ-028 Overrun: with TX busy, write 6 bytes back to back -> bytes 1-5 transmitted in order (one in the shifter, four in the FIFO), byte 6 dropped. STATUS read returns 8'h0B during the burst. A second STATUS read returns OVERRUN=0.
REQ-029 Interrupt: write 8'h01 to E2, then 8'h55 to E0 -> RAISE=1 one cycle after the STOP bit ends. ACK pulse -> RAISE=0 the next cycle. With IRQ_EN=0 the same frame yields no RAISE.
REQ-030 Back-to-back: queue 8'h00 and 8'hFF -> 20 contiguous bit periods, no idle gap, a single RAISE after the second frame.
REQ-031 Reset mid-frame: assert RESET during data bit 3 of 8'h3C with 2 bytes queued -> TX=1 next cycle, STATUS=8'h00, no further frames, RAISE=0.
REQ-032 Bus read timing: read E1 at cycle N -> BUS_DATA valid only in cycle N+1. A read of 8'hD0 (outside the window) leaves BUS_DATA high-Z.

Source files
------------

// File: rtl/uart_tx_periph_if.sv
// CPU-side address/strobe/interrupt signals of the UART transmitter peripheral.
// The shared 8-bit data bus stays a separate inout port on the peripheral.
interface uart_tx_periph_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: 3-register bus window, 4-byte FIFO,
// 8N1 shifter and a transmit-complete interrupt.
module uart_tx_periph #(
  parameter logic [7:0]  BASE_ADDR = 8'hE0,
  parameter int unsigned BAUD_DIV  = 868
) (
  input  logic            CLK,
  input  logic            RESET,
  uart_tx_periph_if.slave bus,
  inout  wire  [7:0]      BUS_DATA,
  output logic            TX
);
  localparam logic [7:0]  ADDR_DATA   = BASE_ADDR;
  localparam logic [7:0]  ADDR_STATUS = BASE_ADDR + 8'd1;
  localparam logic [7:0]  ADDR_CTRL   = BASE_ADDR + 8'd2;
  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        irq_en_q, irq_en_d;
  logic        overrun_q, overrun_d;
  logic        raise_q, raise_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic wr_data, wr_ctrl, rd_status, fifo_full, fifo_empty, busy;
  logic push, pop, frame_done, baud_end;

  assign wr_data    = bus.BUS_WE && (bus.BUS_ADDR == ADDR_DATA);
  assign wr_ctrl    = bus.BUS_WE && (bus.BUS_ADDR == ADDR_CTRL);
  assign rd_status  = !bus.BUS_WE && (bus.BUS_ADDR == ADDR_STATUS);
  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign baud_end   = (baud_q == BAUD_LAST);

  // A full FIFO still accepts a byte when the shifter pops in the same cycle.
  assign push = wr_data && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 16'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        if (!fifo_empty) begin
          state_d = S_START;
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (!fifo_empty) begin
            state_d = S_START;
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
          end else begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // TX is registered from the next state so the line changes with the state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + 2'(push);
    rd_ptr_d   = rd_ptr_q + 2'(pop);
    count_d    = count_q + 3'(push) - 3'(pop);
    irq_en_d   = wr_ctrl ? BUS_DATA[0] : irq_en_q;
    overrun_d  = (wr_data && fifo_full && !pop) ? 1'b1 :
                 rd_status ? 1'b0 : overrun_q;
    raise_d    = (frame_done && irq_en_q) ? 1'b1 :
                 bus.BUS_INTERRUPT_ACK ? 1'b0 : raise_q;
    rd_valid_d = 1'b0;
    rd_data_d  = 8'h00;
    if (!bus.BUS_WE) begin
      case (bus.BUS_ADDR)
        ADDR_DATA:   rd_valid_d = 1'b1;
        ADDR_STATUS: begin
          rd_valid_d = 1'b1;
          rd_data_d  = {4'b0000, overrun_q, irq_en_q, fifo_full, busy};
        end
        ADDR_CTRL: begin
          rd_valid_d = 1'b1;
          rd_data_d  = {7'b0000000, irq_en_q};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) fifo_mem[wr_ptr_q] <= BUS_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      irq_en_q   <= 1'b0;
      overrun_q  <= 1'b0;
      raise_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      overrun_q  <= overrun_d;
      raise_q    <= raise_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign TX                      = tx_q;
  assign bus.BUS_INTERRUPT_RAISE = raise_q;
  assign BUS_DATA                = (rd_valid_q && !RESET) ? rd_data_q : 8'hzz;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: a frame-level reference model queues
// expected serial frames, read responses and interrupt edges; monitors compare.
module tb_uart_tx_periph;
  localparam int         B     = 4;
  localparam logic [7:0] BASE  = 8'hE0;
  localparam int         FRAME = 10 * B;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic [7:0] tb_wdata = 8'h00;
  logic       tb_oe = 1'b0;
  wire  [7:0] bus_data;

  assign bus_data = tb_oe ? tb_wdata : 8'hzz;

  uart_tx_periph_if bus ();

  uart_tx_periph #(.BASE_ADDR(BASE), .BAUD_DIV(B)) dut (
    .CLK(clk), .RESET(rst), .bus(bus), .BUS_DATA(bus_data), .TX(tx)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  ev_t        exp_tx[$];
  ev_t        exp_rd[$];
  ev_t        exp_irq[$];
  logic [7:0] mq[$];
  bit         m_frame = 1'b0;
  int         m_frame_end = 0;
  bit         m_irq_en = 1'b0, m_ovr = 1'b0, m_raise = 1'b0;
  bit         m_pop, m_done, m_busy_pre, m_full_pre, m_irq_pre, m_ovr_pre, m_new_raise;
  logic [7:0] m_off, m_v;
  ev_t        m_e;

  // Reference model: one evaluation per clock, over the inputs of the cycle just ended.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_tx.delete();
      m_frame  = 1'b0;
      m_irq_en = 1'b0;
      m_ovr    = 1'b0;
      if (m_raise) begin
        m_e.data = 8'h00; m_e.cyc = cyc + 1; exp_irq.push_back(m_e);
      end
      m_raise = 1'b0;
    end else begin
      m_pop      = 1'b0;
      m_done     = 1'b0;
      m_busy_pre = m_frame || (mq.size() != 0);
      m_full_pre = (mq.size() == 4);
      m_irq_pre  = m_irq_en;
      m_ovr_pre  = m_ovr;
      if (m_frame && cyc == m_frame_end) begin
        if (mq.size() == 0) begin m_frame = 1'b0; m_done = 1'b1; end
        else m_pop = 1'b1;
      end else if (!m_frame && mq.size() != 0) begin
        m_pop = 1'b1;
      end
      if (m_pop) begin
        m_e.data = mq.pop_front(); m_e.cyc = cyc + 1; exp_tx.push_back(m_e);
        m_frame = 1'b1;
        m_frame_end = cyc + FRAME;
      end
      m_off = bus.BUS_ADDR - BASE;
      if (bus.BUS_WE) begin
        if (m_off == 8'd0) begin
          if (mq.size() < 4) mq.push_back(bus_data);
          else m_ovr = 1'b1;
        end else if (m_off == 8'd2) begin
          m_irq_en = bus_data[0];
        end
      end else if (m_off < 8'd3) begin
        if (m_off == 8'd1)      m_v = {4'b0, m_ovr_pre, m_irq_pre, m_full_pre, m_busy_pre};
        else if (m_off == 8'd2) m_v = {7'b0, m_irq_pre};
        else                    m_v = 8'h00;
        m_e.data = m_v; m_e.cyc = cyc + 1; exp_rd.push_back(m_e);
        if (m_off == 8'd1) m_ovr = 1'b0;
      end
      m_new_raise = (m_done && m_irq_pre) ? 1'b1 : bus.BUS_INTERRUPT_ACK ? 1'b0 : m_raise;
      if (m_new_raise != m_raise) begin
        m_e.data = {7'b0, m_new_raise}; m_e.cyc = cyc + 1; exp_irq.push_back(m_e);
      end
      m_raise = m_new_raise;
    end
    cyc++;
  end

  bit         t_in_frame = 1'b0, t_shape_ok, t_exp_ok;
  int         t_k;
  logic       t_cur;
  logic [7:0] t_got, t_exp;
  ev_t        t_e;

  // Serial-line monitor: decodes each frame and checks start cycle, shape and byte.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        t_in_frame = 1'b0;
      end else begin
        if (!t_in_frame && tx !== 1'b1) begin
          t_in_frame = 1'b1; t_k = 0; t_shape_ok = 1'b1; t_got = 8'h00;
          checks++;
          if (exp_tx.size() == 0) begin
            errors++; t_exp_ok = 1'b0;
            $display("FAIL tx_start: unexpected frame start at cycle %0d, required none", cyc);
          end else begin
            t_e = exp_tx.pop_front(); t_exp_ok = 1'b1; t_exp = t_e.data;
            if (t_e.cyc != cyc) begin
              errors++;
              $display("FAIL tx_start: frame started at cycle %0d, required %0d", cyc, t_e.cyc);
            end
          end
        end
        if (t_in_frame) begin
          if (t_k % B == 0) t_cur = tx;
          else if (tx !== t_cur) t_shape_ok = 1'b0;
          if (t_k / B == 0 && tx !== 1'b0) t_shape_ok = 1'b0;
          if (t_k / B == 9 && tx !== 1'b1) t_shape_ok = 1'b0;
          if (t_k / B >= 1 && t_k / B <= 8 && t_k % B == B / 2) t_got[t_k / B - 1] = tx;
          t_k++;
          if (t_k == FRAME) begin
            t_in_frame = 1'b0;
            if (t_exp_ok) begin
              checks++;
              if (t_got !== t_exp || !t_shape_ok) begin
                errors++;
                $display("FAIL tx_frame: got byte %02h shape_ok=%0d, required byte %02h well-formed",
                         t_got, t_shape_ok, t_exp);
              end else begin
                $display("tx frame %02h ok, ended cycle %0d", t_got, cyc);
              end
            end
          end
        end
      end
    end
  end

  logic r_lvl = 1'b0;

  // Bus-read and interrupt monitors.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_rd.size() != 0 && exp_rd[0].cyc == cyc) begin
        checks++;
        if (bus_data !== exp_rd[0].data) begin
          errors++;
          $display("FAIL bus_read: cycle %0d data %02h, required %02h", cyc, bus_data, exp_rd[0].data);
        end else begin
          $display("bus read cycle %0d data %02h ok", cyc, bus_data);
        end
        void'(exp_rd.pop_front());
      end else if (!tb_oe) begin
        checks++;
        if (bus_data !== 8'hzz) begin
          errors++;
          $display("FAIL bus_hiz: cycle %0d data %02h, required high-Z", cyc, bus_data);
        end
      end
      if (exp_irq.size() != 0 && exp_irq[0].cyc == cyc) begin
        r_lvl = exp_irq[0].data[0];
        void'(exp_irq.pop_front());
        $display("irq edge expected cycle %0d level %0d", cyc, r_lvl);
      end
      checks++;
      if (bus.BUS_INTERRUPT_RAISE !== r_lvl) begin
        errors++;
        $display("FAIL irq_raise: cycle %0d RAISE=%0b, required %0b", cyc, bus.BUS_INTERRUPT_RAISE, r_lvl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus.BUS_ADDR = a; bus.BUS_WE = 1'b1; tb_wdata = d; tb_oe = 1'b1;
    step();
    bus.BUS_WE = 1'b0; tb_oe = 1'b0; bus.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    bus.BUS_ADDR = a; bus.BUS_WE = 1'b0;
    step();
    bus.BUS_ADDR = 8'h00;
    step();
  endtask

  task automatic ack();
    bus.BUS_INTERRUPT_ACK = 1'b1;
    step();
    bus.BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((m_frame || mq.size() != 0) && n < limit) begin step(); n++; end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
    idle(4);
  endtask

  task automatic wait_raise(input int limit);
    int n = 0;
    while (bus.BUS_INTERRUPT_RAISE !== 1'b1 && n < limit) begin step(); n++; end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL raise_timeout: RAISE=%0b after %0d cycles, required 1", bus.BUS_INTERRUPT_RAISE, n);
    end
    idle(2);
    ack();
    idle(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.BUS_ADDR = 8'h00; bus.BUS_WE = 1'b0; bus.BUS_INTERRUPT_ACK = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: TX=%0b, required 1", tx); end
    checks++;
    if (bus.BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_raise: RAISE=%0b, required 0", bus.BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (bus_data !== 8'hzz) begin errors++; $display("FAIL reset_hiz: data %02h, required high-Z", bus_data); end
    mon_en = 1'b1;
    bus_rd(8'hE1);

    // Single byte, then status while busy and idle.
    bus_wr(8'hE0, 8'hA5);
    idle(10);
    bus_rd(8'hE1);
    wait_done(200);
    bus_rd(8'hE1); bus_rd(8'hD0); bus_rd(8'hE2); bus_rd(8'hE0);

    // Overrun burst: six back-to-back writes, sixth is dropped.
    for (int i = 0; i < 6; i++) bus_wr(8'hE0, 8'h10 + 8'(i));
    bus_rd(8'hE1);
    bus_rd(8'hE1);
    wait_done(1000);

    // Interrupt on, ack, then interrupt off.
    bus_wr(8'hE2, 8'h01);
    bus_wr(8'hE0, 8'h55);
    wait_raise(200);
    bus_wr(8'hE2, 8'h00);
    bus_wr(8'hE0, 8'h55);
    wait_done(200);

    // Back-to-back frames with a single completion interrupt.
    bus_wr(8'hE2, 8'h01);
    bus_wr(8'hE0, 8'h00);
    bus_wr(8'hE0, 8'hFF);
    wait_raise(400);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 35)      bus_wr(8'hE0, 8'($urandom));
      else if (r < 43) bus_wr(8'hE2, 8'($urandom));
      else if (r < 48) bus_wr(8'($urandom), 8'($urandom));
      else if (r < 72) begin
        int s;
        s = int'($urandom_range(0, 4));
        case (s)
          0: bus_rd(8'hE0);
          1: bus_rd(8'hE1);
          2: bus_rd(8'hE2);
          3: bus_rd(8'hD0);
          default: bus_rd(8'($urandom));
        endcase
      end
      else if (r < 78) ack();
      else idle(int'($urandom_range(1, 20)));
    end
    wait_done(10000);
    ack();
    idle(3);

    // Reset during data bit 3 of 8'h3C with two bytes queued.
    bus_wr(8'hE2, 8'h01);
    bus_wr(8'hE0, 8'h3C);
    bus_wr(8'hE0, 8'h81);
    bus_wr(8'hE0, 8'h7E);
    idle(16);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx: TX=%0b, required 1", tx); end
    bus_rd(8'hE1);
    idle(120);

    checks++;
    if (exp_tx.size() != 0 || t_in_frame) begin
      errors++; $display("FAIL tx_pending: %0d frames not seen, required 0", exp_tx.size());
    end
    checks++;
    if (exp_rd.size() != 0) begin
      errors++; $display("FAIL rd_pending: %0d reads not seen, required 0", exp_rd.size());
    end
    checks++;
    if (exp_irq.size() != 0) begin
      errors++; $display("FAIL irq_pending: %0d edges not seen, required 0", exp_irq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
